// File: rtl/note_scheduler.sv
// Rhythm-game note sequencer: walks a chart ROM one step at a time, keeps a small
// aging queue of in-flight notes, and presents the oldest note to the hit judge.
module note_scheduler #(
  parameter int DEPTH    = 4,
  parameter int CHART_AW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step_tick,
  output logic [CHART_AW-1:0] chart_addr,
  input  logic [1:0]          chart_data,
  input  logic                delete_note,
  output logic                node_R,
  output logic                node_B,
  output logic [2:0]          offset,
  output logic                miss,
  output logic                playing,
  output logic                done,
  output logic                overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CHART_AW-1:0] LAST_ADDR = {CHART_AW{1'b1}};

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CHART_AW-1:0] addr_q, addr_d;
  logic [PW-1:0]       wrPtr_q, wrPtr_d;
  logic [PW-1:0]       rdPtr_q, rdPtr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                miss_q, miss_d;
  logic                overflow_q, overflow_d;
  logic                lane_q [DEPTH];
  logic                lane_d [DEPTH];
  logic [2:0]          age_q  [DEPTH];
  logic [2:0]          age_d  [DEPTH];

  logic pop;
  logic push;
  logic nonEmpty;
  logic isActive;

  assign nonEmpty = (count_q != '0);
  assign isActive = (state_q == PLAY) || (state_q == DRAIN);

  // Within one step the head is retired first, survivors age, then the chart spawns.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    miss_d     = 1'b0;
    overflow_d = overflow_q;
    lane_d     = lane_q;
    age_d      = age_q;
    pop        = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = PLAY;
          addr_d     = '0;
          wrPtr_d    = '0;
          rdPtr_d    = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      PLAY, DRAIN: begin
        pop    = nonEmpty && (delete_note || (step_tick && age_q[rdPtr_q] == 3'd7));
        miss_d = nonEmpty && step_tick && !delete_note && (age_q[rdPtr_q] == 3'd7);

        if (step_tick) begin
          for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = (age_q[i] == 3'd7) ? 3'd7 : age_q[i] + 3'd1;
          end
        end

        if (step_tick && state_q == PLAY) begin
          if (chart_data == 2'b11) begin
            state_d = DRAIN;
          end else begin
            if (chart_data != 2'b00) begin
              if ((count_q - CW'(pop)) < CW'(DEPTH)) begin
                push = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
            if (addr_q == LAST_ADDR) begin
              state_d = DRAIN;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end

        if (pop) begin
          rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push) begin
          lane_d[wrPtr_q] = chart_data[1];
          age_d[wrPtr_q]  = 3'd0;
          wrPtr_d         = wrPtr_q + 1'b1;
        end
        count_d = count_q - CW'(pop) + CW'(push);

        if (state_q == DRAIN && !nonEmpty) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      miss_q     <= 1'b0;
      overflow_q <= 1'b0;
      lane_q     <= '{default: 1'b0};
      age_q      <= '{default: 3'd0};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      miss_q     <= miss_d;
      overflow_q <= overflow_d;
      lane_q     <= lane_d;
      age_q      <= age_d;
    end
  end

  // Head presentation is decoded straight from the registers so a pop shows next cycle.
  assign chart_addr = addr_q;
  assign playing    = isActive;
  assign done       = (state_q == DONE);
  assign node_R     = isActive && nonEmpty && !lane_q[rdPtr_q];
  assign node_B     = isActive && nonEmpty && lane_q[rdPtr_q];
  assign offset     = nonEmpty ? age_q[rdPtr_q] : 3'd0;
  assign miss       = miss_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_note_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       step_tick;
  logic [7:0] chart_addr;
  logic [1:0] chart_data;
  logic       delete_note;
  logic       node_R;
  logic       node_B;
  logic [2:0] offset;
  logic       miss;
  logic       playing;
  logic       done;
  logic       overflow;

  typedef struct packed {
    logic       nodeR;
    logic       nodeB;
    logic [2:0] offset;
    logic       miss;
    logic       playing;
    logic       done;
    logic       overflow;
    logic [7:0] addr;
  } exp_t;

  typedef struct {
    int    due;
    string name;
    exp_t  exp;
  } rec_t;

  rec_t       sb[$];
  logic [1:0] rom [256];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       act;

  note_scheduler #(.DEPTH(4), .CHART_AW(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .step_tick(step_tick),
    .chart_addr(chart_addr),
    .chart_data(chart_data),
    .delete_note(delete_note),
    .node_R(node_R),
    .node_B(node_B),
    .offset(offset),
    .miss(miss),
    .playing(playing),
    .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous chart ROM model: data follows the address one clock later.
  always @(posedge clk) chart_data <= rom[chart_addr];

  assign act = {node_R, node_B, offset, miss, playing, done, overflow, chart_addr};

  always @(negedge clk) begin
    rec_t r;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      r = sb.pop_front();
      checks++;
      if (r.due != cyc) begin
        errors++;
        $display("[TB] FAIL %s: stale entry due cycle %0d, now %0d", r.name, r.due, cyc);
      end else if (act !== r.exp) begin
        errors++;
        $display("[TB] FAIL %s: got R=%b B=%b off=%0d miss=%b play=%b done=%b ovf=%b addr=%0d, expected R=%b B=%b off=%0d miss=%b play=%b done=%b ovf=%b addr=%0d",
                 r.name, act.nodeR, act.nodeB, act.offset, act.miss, act.playing, act.done,
                 act.overflow, act.addr, r.exp.nodeR, r.exp.nodeB, r.exp.offset, r.exp.miss,
                 r.exp.playing, r.exp.done, r.exp.overflow, r.exp.addr);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic r, input logic b, input int off, input logic m,
                              input logic p, input logic d, input logic o, input int a);
    exp_t e;
    e.nodeR    = r;
    e.nodeB    = b;
    e.offset   = 3'(off);
    e.miss     = m;
    e.playing  = p;
    e.done     = d;
    e.overflow = o;
    e.addr     = 8'(a);
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    rec_t r;
    r.due  = cyc;
    r.name = name;
    r.exp  = e;
    sb.push_back(r);
  endtask

  // One-cycle pulse on the selected inputs; returns just after the edge that sampled them.
  task automatic applyStimulus(input logic doStart, input logic doTick, input logic doDelete);
    @(posedge clk);
    #1;
    start       = doStart;
    step_tick   = doTick;
    delete_note = doDelete;
    @(posedge clk);
    #1;
    start       = 1'b0;
    step_tick   = 1'b0;
    delete_note = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 2'b00;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    step_tick   = 1'b0;
    delete_note = 1'b0;
    clearRom();
    rom[0] = 2'b01; rom[1] = 2'b00; rom[2] = 2'b10; rom[3] = 2'b11;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
    nextCycle();
    rst = 1'b0;

    // Basic chart: red, rest, blue, end.
    applyStimulus(1, 0, 0); checkOutput("t1_start", mk(0, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus(0, 1, 0); checkOutput("t1_tick1", mk(1, 0, 0, 0, 1, 0, 0, 1));
    applyStimulus(0, 1, 0); checkOutput("t1_tick2", mk(1, 0, 1, 0, 1, 0, 0, 2));
    applyStimulus(0, 1, 0); checkOutput("t1_tick3", mk(1, 0, 2, 0, 1, 0, 0, 3));
    applyStimulus(0, 0, 1); checkOutput("t1_delred", mk(0, 1, 0, 0, 1, 0, 0, 3));
    applyStimulus(0, 1, 0); checkOutput("t1_tick4", mk(0, 1, 1, 0, 1, 0, 0, 3));
    applyStimulus(0, 0, 1); checkOutput("t1_delblue", mk(0, 0, 0, 0, 1, 0, 0, 3));
    nextCycle();            checkOutput("t1_done", mk(0, 0, 0, 0, 0, 1, 0, 3));

    // Unhit red note ages to 7 then expires with a miss.
    clearRom();
    rom[0] = 2'b01; rom[9] = 2'b11;
    applyStimulus(1, 0, 0); checkOutput("t2_start", mk(0, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus(0, 1, 0); checkOutput("t2_tick1", mk(1, 0, 0, 0, 1, 0, 0, 1));
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("t2_age%0d", k), mk(1, 0, k, 0, 1, 0, 0, k + 1));
    end
    applyStimulus(0, 1, 0); checkOutput("t2_miss", mk(0, 0, 0, 1, 1, 0, 0, 9));
    nextCycle();            checkOutput("t2_missend", mk(0, 0, 0, 0, 1, 0, 0, 9));
    applyStimulus(0, 1, 0); checkOutput("t2_end", mk(0, 0, 0, 0, 1, 0, 0, 9));
    nextCycle();            checkOutput("t2_done", mk(0, 0, 0, 0, 0, 1, 0, 9));

    // Hit at offset 3; the following blue note keeps its own age.
    clearRom();
    rom[0] = 2'b01; rom[2] = 2'b10; rom[4] = 2'b11;
    applyStimulus(1, 0, 0); checkOutput("t3_start", mk(0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k <= 3; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("t3_tick%0d", k + 1), mk(1, 0, k, 0, 1, 0, 0, k + 1));
    end
    applyStimulus(0, 0, 1); checkOutput("t3_hit", mk(0, 1, 1, 0, 1, 0, 0, 4));
    applyStimulus(0, 1, 0); checkOutput("t3_end", mk(0, 1, 2, 0, 1, 0, 0, 4));
    applyStimulus(0, 0, 1); checkOutput("t3_delblue", mk(0, 0, 0, 0, 1, 0, 0, 4));
    nextCycle();            checkOutput("t3_done", mk(0, 0, 0, 0, 0, 1, 0, 4));

    // Five notes into a four-deep queue, then delete+tick on an age-7 head.
    clearRom();
    rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b01; rom[3] = 2'b10; rom[4] = 2'b01;
    rom[8] = 2'b01; rom[10] = 2'b11;
    applyStimulus(1, 0, 0); checkOutput("t4_start", mk(0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k <= 3; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("t4_fill%0d", k + 1), mk(1, 0, k, 0, 1, 0, 0, k + 1));
    end
    for (int k = 4; k <= 7; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("t4_full%0d", k + 1), mk(1, 0, k, 0, 1, 0, 1, k + 1));
    end
    applyStimulus(0, 1, 1); checkOutput("t4_delexp", mk(0, 1, 7, 0, 1, 0, 1, 9));
    applyStimulus(0, 1, 0); checkOutput("t4_miss1", mk(1, 0, 7, 1, 1, 0, 1, 10));
    applyStimulus(0, 1, 0); checkOutput("t4_miss2", mk(0, 1, 7, 1, 1, 0, 1, 10));
    applyStimulus(0, 0, 1); checkOutput("t4_del1", mk(1, 0, 2, 0, 1, 0, 1, 10));
    applyStimulus(0, 0, 1); checkOutput("t4_del2", mk(0, 0, 0, 0, 1, 0, 1, 10));
    nextCycle();            checkOutput("t4_done", mk(0, 0, 0, 0, 0, 1, 1, 10));

    // Restart clears overflow; then reset mid-song with three notes queued.
    clearRom();
    rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b01;
    applyStimulus(1, 0, 0); checkOutput("t5_restart", mk(0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k <= 2; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("t5_tick%0d", k + 1), mk(1, 0, k, 0, 1, 0, 0, k + 1));
    end
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("t5_asyncrst", mk(0, 0, 0, 0, 0, 0, 0, 0));
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 1, 0); checkOutput("t5_idletick", mk(0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1, 0, 0); checkOutput("t5_resume", mk(0, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus(0, 1, 0); checkOutput("t5_fresh", mk(1, 0, 0, 0, 1, 0, 0, 1));

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
